fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter sharing one async FIFO write port among NUM_REQ requesters in the write-clock domain. Grants one requester at a time for a burst of up to BURST words, drives the FIFO wt_en/wdata combinationally from the granted requester, and uses the FIFO full flag as backpressure so the FIFO never sees an overflowing write. Sits directly in front of the async FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port signals shared by the arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          full;
  logic                          wt_en;
  logic [DATA_WIDTH-1:0]         wdata;

  modport master (
    input  req, req_data, full,
    output gnt, wt_en, wdata
  );

  modport slave (
    output req, req_data, full,
    input  gnt, wt_en, wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for one async FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int IW        = $clog2(NUM_REQ),
  localparam int BW        = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic                 wt_clk,
  input  logic                 rst_n,
  fifo_wr_arbiter_if.master    bus,
  output logic [IW-1:0]        owner,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] wr_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

  state_t               state, state_nxt;
  logic [IW-1:0]        owner_nxt;
  logic [IW-1:0]        last, last_nxt;
  logic [BW-1:0]        beat, beat_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [IW-1:0]        pick;
  logic [IW-1:0]        cand;
  logic                 accept;

  // Scan from the far end so the nearest requester after 'last' is the one kept.
  always_comb begin
    pick = last;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (bus.req[cand]) pick = cand;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    beat_nxt  = beat;
    cnt_nxt   = wr_count;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          owner_nxt = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[owner]) begin
          last_nxt  = owner;
          beat_nxt  = '0;
          state_nxt = IDLE;
        end else if (!bus.full) begin
          accept  = 1'b1;
          cnt_nxt = wr_count + CNT_WIDTH'(1);
          if (beat == BEAT_LAST) begin
            last_nxt  = owner;
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= IW'(NUM_REQ - 1);
      beat     <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      beat     <= beat_nxt;
      wr_count <= cnt_nxt;
    end
  end

  // rst_n gating kills an in-flight word the moment reset asserts.
  assign bus.wt_en = accept & rst_n;
  assign bus.gnt   = (accept & rst_n) ? (NUM_REQ'(1) << owner) : '0;
  assign bus.wdata = rst_n ? bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy      = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int BURST   = 4;
  localparam int CNT_W   = 8;

  logic       wt_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] owner;
  logic       busy;
  logic [CNT_W-1:0] wr_count;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BURST(BURST), .CNT_WIDTH(CNT_W)
  ) dut (
    .wt_clk(wt_clk), .rst_n(rst_n), .bus(bus),
    .owner(owner), .busy(busy), .wr_count(wr_count)
  );

  always #5 wt_clk = ~wt_clk;

  typedef struct { int idx; logic [DW-1:0] data; } wr_t;
  typedef struct { int own; bit bsy; int cnt; } st_t;

  wr_t exp_wr[$];
  st_t exp_st[$];

  int vectors = 0;
  int miscompares = 0;

  bit            m_grant;
  int            m_owner, m_last, m_beat, m_cnt;
  bit            p_valid [NUM_REQ];
  logic [DW-1:0] p_data  [NUM_REQ];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(int last_i, logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(last_i + k) % NUM_REQ]) return (last_i + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic drive_pending();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]               = p_valid[i];
      bus.req_data[i*DW +: DW] = p_data[i];
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_owner = 0; m_last = NUM_REQ - 1; m_beat = 0; m_cnt = 0;
  endtask

  // One write-clock cycle: new requester activity, then the reference decision for the next edge.
  task automatic cycle(int drop_pct, int raise_pct, int full_pct, logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] r;
    bit f;
    int p;
    @(negedge wt_clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!p_valid[i]) begin
        if (mask[i] && $urandom_range(0, 99) < raise_pct) begin
          p_valid[i] = 1'b1;
          p_data[i]  = DW'($urandom);
        end
      end else if ($urandom_range(0, 99) < drop_pct) begin
        p_valid[i] = 1'b0;
        p_data[i]  = DW'($urandom);
      end
    end
    drive_pending();
    f = ($urandom_range(0, 99) < full_pct);
    bus.full = f;
    for (int i = 0; i < NUM_REQ; i++) r[i] = p_valid[i];

    if (!m_grant) begin
      p = rr_pick(m_last, r);
      if (p >= 0) begin m_grant = 1; m_owner = p; end
    end else if (!p_valid[m_owner]) begin
      m_last = m_owner; m_beat = 0; m_grant = 0;
    end else if (!f) begin
      exp_wr.push_back('{m_owner, p_data[m_owner]});
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      p_valid[m_owner] = 1'b0;
      if (m_beat == BURST - 1) begin
        m_last = m_owner; m_beat = 0; m_grant = 0;
      end else begin
        m_beat++;
      end
    end
    exp_st.push_back('{m_owner, m_grant, m_cnt});
  endtask

  task automatic do_reset(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge wt_clk);
      rst_n = 1'b0;
      drive_pending();
      model_reset();
      exp_st.push_back('{0, 0, 0});
      #1;
      chk("rst_wt_en", bus.wt_en, 0);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_owner", owner, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_count", wr_count, 0);
    end
  endtask

  initial begin : write_monitor
    wr_t w;
    forever begin
      @(negedge wt_clk);
      #2;
      if (bus.wt_en === 1'b1) begin
        chk("write_expected", 64'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("gnt", bus.gnt, 64'(1) << w.idx);
          chk("wdata", bus.wdata, w.data);
          chk("no_write_when_full", bus.full, 0);
        end
      end else begin
        chk("gnt_without_wt_en", bus.gnt, 0);
      end
    end
  end

  initial begin : status_monitor
    st_t s;
    forever begin
      @(posedge wt_clk);
      #1;
      if (exp_st.size() > 0) begin
        s = exp_st.pop_front();
        chk("owner", owner, s.own);
        chk("busy", busy, s.bsy);
        chk("wr_count", wr_count, s.cnt);
      end
    end
  end

  initial begin : main
    int guard;
    bus.req = '0; bus.req_data = '0; bus.full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin p_valid[i] = 0; p_data[i] = '0; end
    model_reset();
    do_reset(3);

    // single requester, continuous words
    for (int c = 0; c < 14; c++) cycle(0, 100, 0, 4'b0001);
    // all requesters saturated, rotation 0,1,2,3,...
    for (int c = 0; c < 60; c++) cycle(0, 100, 0, 4'b1111);
    // random traffic with backpressure and releases
    for (int c = 0; c < 300; c++) cycle(6, 50, 30, 4'b1111);
    // heavy backpressure on a sparse set
    for (int c = 0; c < 80; c++) cycle(3, 80, 60, 4'b0101);

    // reset landing during beat 2 of a burst
    guard = 0;
    while (!(m_grant && m_beat == 2) && guard < 60) begin
      cycle(0, 100, 0, 4'b1111);
      guard++;
    end
    chk("mid_burst_reached", 64'(guard < 60), 1);
    do_reset(2);
    for (int c = 0; c < 20; c++) cycle(0, 100, 0, 4'b1110);

    // long run so the narrow counter wraps
    for (int c = 0; c < 420; c++) cycle(2, 90, 10, 4'b1111);
    for (int c = 0; c < 10; c++) cycle(100, 0, 0, 4'b0000);

    @(negedge wt_clk);
    #3;
    chk("writes_outstanding", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
